stream_demux2: RTL
==================

# stream_demux2

Two-way stream demultiplexer with per-output buffering. It steers each accepted WIDTH-bit word from one valid/ready input stream to one of two output streams, chosen by a per-word select bit. It sits in the CPU datapath wherever one producer feeds two independent consumers, for example routing issued operations to the ALU or the load/store path. Each output has a 2-entry FIFO, so one stalled consumer never blocks traffic to the other.

## Interface
Parameters:
- WIDTH, 32, payload width in bits

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_data  in  WIDTH  input payload
- in_sel  in  1  destination: 0 = output 0, 1 = output 1
- in_valid  in  1  input word present
- in_ready  out  1  block can accept the word on in_data/in_sel
- out0_data  out  WIDTH  output 0 payload (head of FIFO 0)
- out0_valid  out  1  output 0 word present
- out0_ready  in  1  consumer 0 accepts
- out1_data  out  WIDTH  output 1 payload (head of FIFO 1)
- out1_valid  out  1  output 1 word present
- out1_ready  in  1  consumer 1 accepts

## Operation
- Input transfer: in_valid && in_ready at a rising edge. The word and its select are sampled together.
- in_ready = !full[in_sel] && rst_n.
  - Combinational from registered full flags, in_sel and rst_n only.
  - No path from out*_ready to in_ready.
- The accepted word is written to FIFO[in_sel]. The other FIFO is untouched.
- Each FIFO holds 2 entries, implemented as 2 storage regs, 1-bit write and read pointers, and a 2-bit count.
  - Pointers wrap 1 -> 0.
  - full = (count == 2); empty = (count == 0).
- Output n transfer: outn_valid && outn_ready at a rising edge. Pops the head entry.
- outn_valid = !empty[n]; outn_data = storage[n][rd_ptr[n]].
  - Both are registered state, with no combinational path from the inputs.
- Ordering:
  - Strict FIFO order per output.
  - No ordering relation between the two outputs.
  - No word is ever dropped or duplicated.
- Simultaneous push and pop on the same FIFO:
  - count unchanged, both pointers advance.
  - Allowed when count is 1.
  - Not possible when count is 2, because in_ready is low.
  - When count is 0, only the push occurs, since there is nothing to pop.
- Push to one FIFO and pop from the other in the same cycle are fully independent.
- in_valid low: in_data and in_sel are ignored, including X values.

## Timing
- Reset (rst_n low at a rising edge):
  - Both counts and pointers go to 0 and storage clears to 0.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0.
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after release.
- Reset mid-operation discards all buffered words. No partial transfer completes in the reset cycle.
- Latency: a word accepted at edge k is visible on outn_data/outn_valid after edge k, so it can be consumed at edge k+1. There is no input-to-output bypass.
- Throughput: 1 word/cycle per output when the consumer is always ready. Aggregate input rate is 1 word/cycle.
- Backpressure: after a consumer stalls, up to 2 words are absorbed. The third word to that output sees in_ready = 0 until a pop edge has occurred. in_ready rises in the cycle after the pop.
- Valid/data stability: outn_valid and outn_data hold until popped. Once outn_valid is asserted, it does not deassert without a transfer, except at reset.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, both out valids 0 and data 0. After release, in_ready = 1 and nothing is enqueued.
- Alternating steer: send 0xA0000001 (sel 0) and 0xB0000002 (sel 1) back-to-back with both consumers ready -> each appears on its output one cycle after acceptance; in_ready stays 1.
- Full boundary: out0_ready = 0; send 0x11, 0x22, 0x33 to sel 0 -> the first two are accepted; in_ready = 0 on 0x33. Raise out0_ready -> 0x11 pops, 0x33 is accepted the next cycle, and output order is 0x11, 0x22, 0x33.
- Independence: out0 full and stalled; send 0x44 with sel 1 -> in_ready = 1, 0x44 appears on out1, and FIFO 0 contents are unchanged.
- Simultaneous push/pop at count 1: FIFO 1 holds 0x55, out1_ready = 1, push 0x66 with sel 1 -> count stays 1, out1_data goes 0x55 then 0x66. Continue for 8 words to exercise pointer wrap with no loss.
- Reset mid-stream: both FIFOs at count 2; pulse rst_n low for 1 cycle -> both valids 0 the next cycle, and previously buffered words never appear.

Source files
------------

// File: rtl/stream_demux2_if.sv
// Handshake bundle for the two-way stream demultiplexer: one valid/ready input
// stream (with a per-word select) and two valid/ready output streams.
interface stream_demux2_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    // slave is the demux itself; master is the producer/consumer side
    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid
    );

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid
    );
endinterface

// File: rtl/stream_demux2.sv
// Two-way stream demultiplexer: each accepted word is steered by in_sel into
// one of two independent 2-entry FIFOs, so a stalled consumer never blocks the other.
module stream_demux2 #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_demux2_if.slave bus
);
    logic [WIDTH-1:0] mem_q [2][2];
    logic [WIDTH-1:0] mem_d [2][2];
    logic [1:0]       cnt_q [2];
    logic [1:0]       cnt_d [2];
    // bit n of each vector belongs to FIFO n
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       full, empty, push, pop;
    logic             in_rdy;

    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full     = '0;
        empty    = '0;
        push     = '0;
        pop      = '0;

        for (int n = 0; n < 2; n++) begin
            full[n]  = (cnt_q[n] == 2'd2);
            empty[n] = (cnt_q[n] == 2'd0);
        end

        // in_ready depends only on registered fullness, the select and reset
        in_rdy  = rst_n && !full[bus.in_sel];
        push[0] = bus.in_valid && in_rdy && !bus.in_sel;
        push[1] = bus.in_valid && in_rdy &&  bus.in_sel;
        pop[0]  = !empty[0] && bus.out0_ready;
        pop[1]  = !empty[1] && bus.out1_ready;

        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_d[n][wr_ptr_q[n]] = bus.in_data;
                wr_ptr_d[n]           = !wr_ptr_q[n];
            end
            if (pop[n]) begin
                rd_ptr_d[n] = !rd_ptr_q[n];
            end
            case ({push[n], pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + 2'd1;
                2'b01:   cnt_d[n] = cnt_q[n] - 2'd1;
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                cnt_q[n] <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    mem_q[n][e] <= '0;
                end
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out0_valid = (cnt_q[0] != 2'd0);
    assign bus.out1_valid = (cnt_q[1] != 2'd0);
    assign bus.out0_data  = mem_q[0][rd_ptr_q[0]];
    assign bus.out1_data  = mem_q[1][rd_ptr_q[1]];
endmodule
